arp_rx: RTL and testbench

Receive-side ARP parser on the GMII RX byte stream. Strips preamble/SFD, checks the Ethernet header and the ARP payload, and reports the sender MAC/IP with the request/reply type. The controller uses this to trigger `arp_tx`: a request from a peer becomes a reply, and the peer's MAC/IP become `des_mac`/`des_ip`. FCS is not checked here.

---
 rtl/arp_pkg.sv | 23 ++
 rtl/arp_rx.sv | 142 ++++++++++++++
 tb/tb_arp_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants and the receive FSM state type.
// Used by both arp_rx and arp_tx so the two sides agree on framing.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ   = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY = 16'd2;
    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;

    localparam logic [5:0]  PRE_LAST     = 6'd7;
    localparam logic [5:0]  ETH_LAST     = 6'd13;
    localparam logic [5:0]  ARP_LAST     = 6'd27;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        ETH_HEAD = 3'd2,
        ARP_DATA = 3'd3,
        RX_END   = 3'd4
    } arp_rx_state_t;

endpackage

// File: rtl/arp_rx.sv
// GMII receive-side ARP parser: strips preamble/SFD, filters on destination
// MAC, EtherType and target IP, and reports the sender MAC/IP and opcode.
module arp_rx
    import arp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    arp_rx_state_t state;
    logic [5:0]    cnt;
    logic [47:0]   dmac_sh;
    logic [7:0]    etype_hi;
    logic [15:0]   op_sh;
    logic [47:0]   smac_sh;
    logic [31:0]   sip_sh;
    logic [31:0]   tip_sh;

    // Full values including the byte currently on the bus, used on the
    // cycle that completes each field.
    logic [47:0] dmac_full;
    logic [15:0] etype_full;
    logic [31:0] tip_full;
    logic        dmac_ok;
    logic        op_ok;

    assign dmac_full  = {dmac_sh[39:0], gmii_rxd};
    assign etype_full = {etype_hi, gmii_rxd};
    assign tip_full   = {tip_sh[23:0], gmii_rxd};
    assign dmac_ok    = (dmac_full == BOARD_MAC) || (dmac_full == 48'hFFFF_FFFF_FFFF);
    assign op_ok      = (op_sh == ARP_OP_REQ) || (op_sh == ARP_OP_REPLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dmac_sh     <= '0;
            etype_hi    <= '0;
            op_sh       <= '0;
            smac_sh     <= '0;
            sip_sh      <= '0;
            tip_sh      <= '0;
            arp_rx_done <= 1'b0;
            arp_rx_type <= 1'b0;
            src_mac     <= '0;
            src_ip      <= '0;
        end else begin
            arp_rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (gmii_rx_dv && gmii_rxd == ETH_PREAMBLE) begin
                        state <= PREAMBLE;
                        cnt   <= 6'd1;
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt < PRE_LAST) begin
                        if (gmii_rxd == ETH_PREAMBLE) begin
                            cnt <= cnt + 6'd1;
                        end else begin
                            state <= RX_END;
                            cnt   <= '0;
                        end
                    end else begin
                        // Exactly seven preamble bytes, then the SFD.
                        state <= (gmii_rxd == ETH_SFD) ? ETH_HEAD : RX_END;
                        cnt   <= '0;
                    end
                end

                ETH_HEAD: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt <= 6'd5) dmac_sh <= dmac_full;
                        if (cnt == 6'd12) etype_hi <= gmii_rxd;
                        if (cnt == 6'd5 && !dmac_ok) begin
                            state <= RX_END;
                            cnt   <= '0;
                        end
                        if (cnt == ETH_LAST) begin
                            state <= (etype_full == ETH_TYPE_ARP) ? ARP_DATA : RX_END;
                            cnt   <= '0;
                        end
                    end
                end

                ARP_DATA: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt >= 6'd6  && cnt <= 6'd7)  op_sh   <= {op_sh[7:0], gmii_rxd};
                        if (cnt >= 6'd8  && cnt <= 6'd13) smac_sh <= {smac_sh[39:0], gmii_rxd};
                        if (cnt >= 6'd14 && cnt <= 6'd17) sip_sh  <= {sip_sh[23:0], gmii_rxd};
                        if (cnt >= 6'd24 && cnt <= 6'd27) tip_sh  <= tip_full;
                        if (cnt == ARP_LAST) begin
                            // Outputs only move together with the done pulse.
                            if (tip_full == BOARD_IP && op_ok) begin
                                src_mac     <= smac_sh;
                                src_ip      <= sip_sh;
                                arp_rx_type <= (op_sh == ARP_OP_REPLY);
                                arp_rx_done <= 1'b1;
                            end
                            state <= RX_END;
                            cnt   <= '0;
                        end
                    end
                end

                RX_END: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// Self-checking bench for arp_rx: table of frames with expected results,
// a done-pulse scoreboard, plus hand-written reset-mid-frame sequence.
module tb_arp_rx;
    import arp_pkg::*;

    logic        clk;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    arp_rx dut (
        .clk         (clk),
        .rst         (rst),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [15:0] op;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [31:0] tip;
        int          npre;
        logic [7:0]  sfd;
        int          trunc;     // ARP byte index where dv drops, -1 = none
        int          gap;
        logic        exp_done;
        logic        exp_type;
        logic [47:0] exp_mac;
        logic [31:0] exp_ip;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [7:0] bq[$];
    vec_t tbl[12];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match a pending expectation exactly.
    always @(negedge clk) begin
        if (!rst && arp_rx_done) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.typ != arp_rx_type || e.mac != src_mac || e.ip != src_ip) begin
                    errors++;
                    $display("FAIL done_pulse got cyc=%0d type=%0b mac=%h ip=%h want cyc=%0d type=%0b mac=%h ip=%h",
                             cyc, arp_rx_type, src_mac, src_ip, e.cyc, e.typ, e.mac, e.ip);
                end
            end
        end
    end

    function automatic vec_t mk(logic [47:0] dmac, logic [15:0] etype, logic [15:0] op,
                                logic [47:0] smac, logic [31:0] sip, logic [31:0] tip,
                                int npre, logic [7:0] sfd, int trunc, int gap,
                                logic ed, logic et, logic [47:0] em, logic [31:0] ei);
        vec_t v;
        v.dmac = dmac; v.etype = etype; v.op = op; v.smac = smac; v.sip = sip; v.tip = tip;
        v.npre = npre; v.sfd = sfd; v.trunc = trunc; v.gap = gap;
        v.exp_done = ed; v.exp_type = et; v.exp_mac = em; v.exp_ip = ei;
        return v;
    endfunction

    task automatic push_bytes(input logic [47:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) bq.push_back(val[i*8 +: 8]);
    endtask

    task automatic build(input vec_t v);
        bq.delete();
        for (int i = 0; i < v.npre; i++) bq.push_back(8'h55);
        bq.push_back(v.sfd);
        push_bytes(v.dmac, 6);
        push_bytes(v.smac, 6);
        push_bytes({32'd0, v.etype}, 2);
        push_bytes(48'h0001_0800_0604, 6);
        push_bytes({32'd0, v.op}, 2);
        push_bytes(v.smac, 6);
        push_bytes({16'd0, v.sip}, 4);
        push_bytes(48'd0, 6);
        push_bytes({16'd0, v.tip}, 4);
        push_bytes(48'hAAAA_BBBB_CCCC, 4);
    endtask

    task automatic check_outs(input string nm, input logic et, input logic [47:0] em, input logic [31:0] ei);
        checks++;
        if (arp_rx_type != et || src_mac != em || src_ip != ei) begin
            errors++;
            $display("FAIL %s got type=%0b mac=%h ip=%h want type=%0b mac=%h ip=%h",
                     nm, arp_rx_type, src_mac, src_ip, et, em, ei);
        end
    endtask

    task automatic send(input int idx, input vec_t v);
        int last_tip;
        int stop;
        exp_t e;
        build(v);
        last_tip = v.npre + 1 + 14 + 27;
        stop = (v.trunc >= 0) ? (v.npre + 1 + 14 + v.trunc) : bq.size();
        for (int i = 0; i < stop; i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = bq[i];
            if (i == last_tip && v.exp_done) begin
                e.cyc = cyc + 1; e.typ = v.exp_type; e.mac = v.exp_mac; e.ip = v.exp_ip;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (v.gap) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_done vec=%0d pending=%0d want 0", idx, sb.size());
            sb.delete();
        end
        check_outs($sformatf("held_vec%0d", idx), v.exp_type, v.exp_mac, v.exp_ip);
        if (v.trunc >= 0) begin
            checks++;
            if (dut.state != IDLE) begin
                errors++;
                $display("FAIL trunc_idle vec=%0d state=%0d want %0d", idx, dut.state, IDLE);
            end
        end
    endtask

    localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BIP  = 32'hC0A8010A;

    initial begin
        rst = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd = 8'h00;

        //              dmac  etype    op     smac             sip           tip           npre sfd  trunc gap  done type mac              ip
        tbl[0]  = mk(BC,   16'h0806, 16'd1, 48'h000A35010203, 32'hC0A801D1, BIP,          7, 8'hD5, -1, 1, 1, 0, 48'h000A35010203, 32'hC0A801D1);
        tbl[1]  = mk(BMAC, 16'h0806, 16'd2, 48'h0A0B0C0D0E0F, 32'hC0A80102, BIP,          7, 8'hD5, -1, 1, 1, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[2]  = mk(BC,   16'h0806, 16'd1, 48'h0200000000AA, 32'hC0A80199, 32'hC0A8010B, 7, 8'hD5, -1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[3]  = mk(BC,   16'h0800, 16'd1, 48'h0200000000AA, 32'hC0A80199, BIP,          7, 8'hD5, -1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[4]  = mk(48'h001122334466, 16'h0806, 16'd1, 48'h0200000000AA, 32'hC0A80199, BIP, 7, 8'hD5, -1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[5]  = mk(BC,   16'h0806, 16'd3, 48'h0200000000AA, 32'hC0A80199, BIP,          7, 8'hD5, -1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[6]  = mk(BC,   16'h0806, 16'd1, 48'h0200000000AA, 32'hC0A80199, BIP,          5, 8'hD5, -1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[7]  = mk(BC,   16'h0806, 16'd1, 48'h0200000000AA, 32'hC0A80199, BIP,          7, 8'hD4, -1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A80102);
        tbl[8]  = mk(BC,   16'h0806, 16'd1, 48'h020000000001, 32'hC0A80164, BIP,          7, 8'hD5, -1, 3, 1, 0, 48'h020000000001, 32'hC0A80164);
        tbl[9]  = mk(BMAC, 16'h0806, 16'd2, 48'h0200000000BB, 32'hC0A80177, BIP,          7, 8'hD5, 20, 2, 0, 0, 48'h020000000001, 32'hC0A80164);
        tbl[10] = mk(BMAC, 16'h0806, 16'd2, 48'h020000000002, 32'hC0A80165, BIP,          7, 8'hD5, -1, 1, 1, 1, 48'h020000000002, 32'hC0A80165);
        tbl[11] = mk(BC,   16'h0806, 16'd1, 48'h0200000000CC, 32'hC0A80188, BIP,          8, 8'hD5, -1, 1, 0, 1, 48'h020000000002, 32'hC0A80165);

        repeat (3) @(negedge clk);
        checks++;
        if (arp_rx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %0b want 0", arp_rx_done);
        end
        check_outs("reset_outs", 1'b0, 48'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) send(i, tbl[i]);

        // Reset in the middle of the Ethernet header.
        build(tbl[1]);
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge clk);
            if (i == 11) begin
                rst = 1'b1;
                #1;
                checks++;
                if (arp_rx_done !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_done got %0b want 0", arp_rx_done);
                end
                check_outs("midrst_outs", 1'b0, 48'd0, 32'd0);
            end else begin
                rst = 1'b0;
            end
            gmii_rx_dv = 1'b1;
            gmii_rxd   = bq[i];
        end
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_pending got %0d want 0", sb.size());
            sb.delete();
        end
        check_outs("midrst_tail", 1'b0, 48'd0, 32'd0);

        send(12, tbl[0]);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
